// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer: one registered one-hot grant, held while requested,
// pre-empted after MAX_HOLD cycles, always followed by one idle bubble cycle.
module rr_grant_sequencer #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               busy,
   output logic               preempt
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e             state;
   logic [ID_W-1:0]    ptr;
   logic [7:0]         hold_cnt;

   logic               win_found;
   logic [ID_W-1:0]    win_id;
   logic [NUM_REQ-1:0] win_oh;
   int unsigned        idx;

   // Circular search starting at ptr; first set request wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_oh    = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!win_found && req[idx[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = idx[ID_W-1:0];
         end
      end
      if (win_found) win_oh[win_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         gnt      <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
         preempt  <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         preempt <= 1'b0;
         unique case (state)
            StIdle: begin
               if (win_found) begin
                  gnt      <= win_oh;
                  gnt_id   <= win_id;
                  busy     <= 1'b1;
                  hold_cnt <= 8'd1;
                  state    <= StGrant;
               end
            end
            StGrant: begin
               if (req[gnt_id] && (hold_cnt < 8'(MAX_HOLD))) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end else begin
                  // Release or hold-limit expiry; either way one bubble cycle follows.
                  gnt      <= '0;
                  busy     <= 1'b0;
                  preempt  <= req[gnt_id];
                  hold_cnt <= '0;
                  state    <= StIdle;
                  ptr      <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   default clocking cb @(posedge clk);
   endclocking

   a_onehot: assert property (disable iff (rst) $onehot0(gnt));
   c_onehot: cover property (disable iff (rst) $onehot(gnt));
   a_busy: assert property (disable iff (rst) busy == (gnt != '0));
   c_busy: cover property (disable iff (rst) busy);
   a_release: assert property (disable iff (rst) busy && !req[gnt_id] |=> !busy);
   c_release: cover property (disable iff (rst) busy && !req[gnt_id]);
   a_preempt: assert property (disable iff (rst) preempt |-> !busy);
   c_preempt: cover property (disable iff (rst) preempt);
   a_hold: assert property (disable iff (rst) busy |-> hold_cnt <= 8'(MAX_HOLD));
   c_hold: cover property (disable iff (rst) busy && hold_cnt == 8'(MAX_HOLD));

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_props
      logic [15:0] wait_cnt;

      // Cycles requester i has been asking without holding the grant.
      always_ff @(posedge clk) begin
         if (rst || !req[i] || gnt[i]) wait_cnt <= '0;
         else                          wait_cnt <= wait_cnt + 16'd1;
      end

      a_past_req: assert property (disable iff (rst) gnt[i] |-> $past(req[i]));
      c_past_req: cover property (disable iff (rst) gnt[i]);
      a_fair: assert property (disable iff (rst)
         req[i] |-> wait_cnt < 16'(NUM_REQ * (MAX_HOLD + 1)));
      c_fair: cover property (disable iff (rst) req[i] && gnt[i] && $past(wait_cnt != '0));
   end

endmodule
